// File: rtl/param_pkg.sv
// Shared types and constants for the parameter-loader command front end.
// No logic; no latency.
// No flow control of its own.
package param_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    CSUM,
    WRITE,
    RESP
  } loader_state_t;

  localparam int PARAM_W = 8;

  localparam logic ADDR_P        = 1'b0;
  localparam logic ADDR_SETPOINT = 1'b1;

  localparam logic [7:0] DEFAULT_SYNC = 8'hA5;
  localparam logic [7:0] DEFAULT_ACK  = 8'h06;
  localparam logic [7:0] DEFAULT_NACK = 8'h15;

  // Frame checksum: XOR of the sync byte and both payload bytes.
  function automatic logic [7:0] frame_csum(input logic [7:0] sync,
                                            input logic [7:0] addr,
                                            input logic [7:0] data);
    return sync ^ addr ^ data;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte idle counter with expiry flag; saturates at LIMIT-1.
// Expiry flag is a decode of the registered count, valid the cycle the count reaches LIMIT-1.
// No flow control; clear has priority over enable.
module frame_timer #(
  parameter int LIMIT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  // Count idle cycles; hold at LAST so the counter never wraps.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/param_loader.sv
// Parses SYNC/ADDR/DATA/CSUM byte frames and writes the p/setpoint registers.
// CSUM in cycle N: write_en in N+1, ACK valid from N+2; NACK valid from N+1.
// rx has no backpressure (bytes during WRITE/RESP are dropped, overrun set); tx held until tx_ready.
module param_loader
  import param_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC,
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter logic [7:0] ACK_BYTE       = DEFAULT_ACK,
  parameter logic [7:0] NACK_BYTE      = DEFAULT_NACK
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               write_en,
  output logic               address,
  output logic [PARAM_W-1:0] param,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               overrun
);

  loader_state_t state;
  logic [7:0]    addr_r;
  logic [7:0]    data_r;
  logic          in_frame;
  logic          timer_expired;

  assign in_frame = (state == ADDR) || (state == DATA) || (state == CSUM);
  assign busy     = (state != IDLE);

  // Timer runs only while waiting for frame bytes; any accepted byte restarts it,
  // and holding it clear outside the frame states gives a zero count on entry.
  frame_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!in_frame || rx_valid),
    .enable  (in_frame),
    .expired (timer_expired)
  );

  // Frame parser, write strobe and response handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr_r   <= '0;
      data_r   <= '0;
      write_en <= 1'b0;
      address  <= ADDR_P;
      param    <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      write_en <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state <= ADDR;
          end
        end
        ADDR: begin
          if (rx_valid) begin
            addr_r <= rx_data;
            state  <= DATA;
          end else if (timer_expired) begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (rx_valid) begin
            data_r <= rx_data;
            state  <= CSUM;
          end else if (timer_expired) begin
            state <= IDLE;
          end
        end
        CSUM: begin
          if (rx_valid) begin
            if ((rx_data == frame_csum(SYNC_BYTE, addr_r, data_r)) && (addr_r <= 8'd1)) begin
              // Strobe goes out while the FSM sits in WRITE.
              write_en <= 1'b1;
              address  <= addr_r[0];
              param    <= data_r;
              state    <= WRITE;
            end else begin
              tx_data  <= NACK_BYTE;
              tx_valid <= 1'b1;
              state    <= RESP;
            end
          end else if (timer_expired) begin
            state <= IDLE;
          end
        end
        WRITE: begin
          if (rx_valid) begin
            overrun <= 1'b1;
          end
          tx_data  <= ACK_BYTE;
          tx_valid <= 1'b1;
          state    <= RESP;
        end
        RESP: begin
          if (rx_valid) begin
            overrun <= 1'b1;
          end
          if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_loader.sv
// Self-checking bench for param_loader: directed scenarios plus randomized frames
// compared against a frame-level model (checksum/address rules, expected register values).
module tb_param_loader;

  localparam int TO = 16;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NACK = 8'h15;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       write_en;
  logic       address;
  logic [7:0] param;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       a;
    logic [7:0] p;
  } wr_t;

  wr_t        wr_q[$];
  logic [7:0] tx_q[$];

  // Model of the register block contents
  logic       exp_addr;
  logic [7:0] exp_param;

  always #5 clk = ~clk;

  param_loader #(
    .SYNC_BYTE      (SYNC),
    .TIMEOUT_CYCLES (TO),
    .ACK_BYTE       (ACK),
    .NACK_BYTE      (NACK)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .write_en (write_en),
    .address  (address),
    .param    (param),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .overrun  (overrun)
  );

  // Observe writes and completed tx handshakes mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (write_en) wr_q.push_back({address, param});
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish (actual=running required=finished)");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d,
                            input logic [7:0] c, input int gap);
    send_byte(SYNC);
    repeat (gap) tick();
    send_byte(a);
    repeat (gap) tick();
    send_byte(d);
    repeat (gap) tick();
    send_byte(c);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy && !tx_valid) begin
        done = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL wait_idle: busy=%0b tx_valid=%0b required busy=0 tx_valid=0 within 200 cycles",
               busy, tx_valid);
    end
  endtask

  // Frame-level rules: accept only a correct checksum on a legal address.
  function automatic void model_frame(input logic [7:0] a, input logic [7:0] d,
                                      input logic [7:0] c, output bit do_write,
                                      output logic [7:0] resp);
    bit good;
    good     = (c == (SYNC ^ a ^ d));
    do_write = good && (a < 8'd2);
    resp     = do_write ? ACK : NACK;
  endfunction

  task automatic test_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if ({write_en, address, param, tx_data, tx_valid, overrun, busy} !== 21'b0) begin
      failures++;
      $display("FAIL reset_values: we=%0b a=%0b p=%h tx=%h txv=%0b ovr=%0b busy=%0b required all 0",
               write_en, address, param, tx_data, tx_valid, overrun, busy);
    end
    reset = 1'b0;
    tick();
    exp_addr  = 1'b0;
    exp_param = 8'h00;
  endtask

  task automatic test_ack_basic();
    wr_q.delete(); tx_q.delete();
    tx_ready = 1'b1;
    send_frame(8'h00, 8'h40, 8'hE5, 1);
    checks++;
    if ({write_en, address, param, tx_valid} !== {1'b1, 1'b0, 8'h40, 1'b0}) begin
      failures++;
      $display("FAIL ack_write_cycle: we=%0b a=%0b p=%h txv=%0b required we=1 a=0 p=40 txv=0",
               write_en, address, param, tx_valid);
    end
    tick();
    checks++;
    if ({write_en, tx_valid, tx_data} !== {1'b0, 1'b1, ACK}) begin
      failures++;
      $display("FAIL ack_resp_cycle: we=%0b txv=%0b tx=%h required we=0 txv=1 tx=06",
               write_en, tx_valid, tx_data);
    end
    tick();
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ack_one_cycle: txv=%0b busy=%0b required 0 0", tx_valid, busy);
    end
    checks++;
    if (wr_q.size() != 1 || tx_q.size() != 1) begin
      failures++;
      $display("FAIL ack_counts: writes=%0d resps=%0d required 1 1", wr_q.size(), tx_q.size());
    end
    exp_addr  = 1'b0;
    exp_param = 8'h40;
  endtask

  task automatic test_stall();
    wr_q.delete(); tx_q.delete();
    tx_ready = 1'b0;
    send_frame(8'h01, 8'h7F, 8'hDB, 0);
    checks++;
    if ({write_en, address, param} !== {1'b1, 1'b1, 8'h7F}) begin
      failures++;
      $display("FAIL stall_write: we=%0b a=%0b p=%h required we=1 a=1 p=7f", write_en, address, param);
    end
    tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== ACK) begin
        failures++;
        $display("FAIL stall_hold[%0d]: txv=%0b tx=%h required txv=1 tx=06", i, tx_valid, tx_data);
      end
      tick();
    end
    tx_ready = 1'b1;
    tick();
    checks++;
    if (tx_valid !== 1'b0 || tx_q.size() != 1 || wr_q.size() != 1) begin
      failures++;
      $display("FAIL stall_release: txv=%0b resps=%0d writes=%0d required 0 1 1",
               tx_valid, tx_q.size(), wr_q.size());
    end
    exp_addr  = 1'b1;
    exp_param = 8'h7F;
  endtask

  task automatic test_nack();
    wr_q.delete(); tx_q.delete();
    tx_ready = 1'b1;
    send_frame(8'h00, 8'h40, 8'h00, 1);
    checks++;
    if ({write_en, tx_valid, tx_data} !== {1'b0, 1'b1, NACK}) begin
      failures++;
      $display("FAIL nack_csum: we=%0b txv=%0b tx=%h required we=0 txv=1 tx=15",
               write_en, tx_valid, tx_data);
    end
    wait_idle();
    send_frame(8'h02, 8'h10, 8'hB7, 1);
    checks++;
    if ({write_en, tx_valid, tx_data} !== {1'b0, 1'b1, NACK}) begin
      failures++;
      $display("FAIL nack_addr: we=%0b txv=%0b tx=%h required we=0 txv=1 tx=15",
               write_en, tx_valid, tx_data);
    end
    wait_idle();
    checks++;
    if (address !== exp_addr || param !== exp_param || wr_q.size() != 0) begin
      failures++;
      $display("FAIL nack_hold: a=%0b p=%h writes=%0d required a=%0b p=%h writes=0",
               address, param, wr_q.size(), exp_addr, exp_param);
    end
  endtask

  task automatic test_timeout();
    wr_q.delete(); tx_q.delete();
    send_byte(SYNC);
    send_byte(8'h00);
    repeat (TO - 1) tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early: busy=%0b required 1 one cycle before expiry", busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0 || wr_q.size() != 0) begin
      failures++;
      $display("FAIL timeout_expire: busy=%0b txv=%0b writes=%0d required 0 0 0",
               busy, tx_valid, wr_q.size());
    end
    send_byte(SYNC);
    send_byte(8'h00);
    repeat (TO - 1) tick();
    send_byte(8'h33);
    send_byte(SYNC ^ 8'h00 ^ 8'h33);
    wait_idle();
    checks++;
    if (wr_q.size() != 1 || tx_q.size() != 1) begin
      failures++;
      $display("FAIL timeout_edge_counts: writes=%0d resps=%0d required 1 1", wr_q.size(), tx_q.size());
    end else begin
      checks++;
      if (wr_q[0] !== {1'b0, 8'h33} || tx_q[0] !== ACK) begin
        failures++;
        $display("FAIL timeout_edge_byte: a=%0b p=%h tx=%h required a=0 p=33 tx=06",
                 wr_q[0].a, wr_q[0].p, tx_q[0]);
      end
    end
    exp_addr  = 1'b0;
    exp_param = 8'h33;
  endtask

  task automatic test_noise();
    wr_q.delete(); tx_q.delete();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL noise_idle: busy=%0b required 0", busy);
    end
    send_frame(8'h01, 8'h20, 8'h84, 0);
    wait_idle();
    checks++;
    if (wr_q.size() != 1 || tx_q.size() != 1) begin
      failures++;
      $display("FAIL noise_counts: writes=%0d resps=%0d required 1 1", wr_q.size(), tx_q.size());
    end else begin
      checks++;
      if (wr_q[0] !== {1'b1, 8'h20} || tx_q[0] !== ACK) begin
        failures++;
        $display("FAIL noise_write: a=%0b p=%h tx=%h required a=1 p=20 tx=06",
                 wr_q[0].a, wr_q[0].p, tx_q[0]);
      end
    end
    exp_addr  = 1'b1;
    exp_param = 8'h20;
  endtask

  task automatic test_overrun();
    wr_q.delete(); tx_q.delete();
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_initial: overrun=%0b required 0", overrun);
    end
    tx_ready = 1'b0;
    send_frame(8'h00, 8'h5A, 8'hFF, 0);
    tick();
    send_byte(SYNC);
    checks++;
    if (overrun !== 1'b1 || tx_valid !== 1'b1 || tx_data !== ACK) begin
      failures++;
      $display("FAIL overrun_set: overrun=%0b txv=%0b tx=%h required 1 1 06", overrun, tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    wait_idle();
    checks++;
    if (tx_q.size() != 1 || wr_q.size() != 1 || busy !== 1'b0 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_complete: resps=%0d writes=%0d busy=%0b ovr=%0b required 1 1 0 1",
               tx_q.size(), wr_q.size(), busy, overrun);
    end
    exp_addr  = 1'b0;
    exp_param = 8'h5A;
  endtask

  task automatic test_reset_mid();
    wr_q.delete(); tx_q.delete();
    send_byte(SYNC);
    send_byte(8'h01);
    reset = 1'b1;
    tick();
    checks++;
    if ({write_en, address, param, tx_data, tx_valid, overrun, busy} !== 21'b0) begin
      failures++;
      $display("FAIL reset_mid_values: we=%0b a=%0b p=%h tx=%h txv=%0b ovr=%0b busy=%0b required all 0",
               write_en, address, param, tx_data, tx_valid, overrun, busy);
    end
    reset = 1'b0;
    send_byte(8'h7E);
    send_byte(SYNC ^ 8'h01 ^ 8'h7E);
    repeat (4) tick();
    checks++;
    if (wr_q.size() != 0 || tx_q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_abandon: writes=%0d resps=%0d busy=%0b required 0 0 0",
               wr_q.size(), tx_q.size(), busy);
    end
    exp_addr  = 1'b0;
    exp_param = 8'h00;
  endtask

  task automatic test_random();
    logic [7:0] a, d, c, resp, nz;
    bit         do_write;
    int         gap, stall, noise;
    for (int f = 0; f < 40; f++) begin
      wr_q.delete(); tx_q.delete();
      noise = $urandom_range(0, 2);
      for (int k = 0; k < noise; k++) begin
        nz = 8'($urandom);
        if (nz == SYNC) nz = 8'h00;
        send_byte(nz);
      end
      a   = 8'($urandom_range(0, 3));
      d   = 8'($urandom);
      c   = SYNC ^ a ^ d;
      if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
      gap   = $urandom_range(0, TO - 1);
      stall = $urandom_range(0, 5);
      model_frame(a, d, c, do_write, resp);
      tx_ready = $urandom_range(0, 1) == 1;
      send_frame(a, d, c, gap);
      repeat (stall) tick();
      tx_ready = 1'b1;
      wait_idle();
      if (do_write) begin
        exp_addr  = a[0];
        exp_param = d;
      end
      checks++;
      if (wr_q.size() != (do_write ? 1 : 0) || tx_q.size() != 1) begin
        failures++;
        $display("FAIL rand_counts[%0d]: writes=%0d resps=%0d required %0d 1",
                 f, wr_q.size(), tx_q.size(), do_write ? 1 : 0);
      end else begin
        checks++;
        if (tx_q[0] !== resp || address !== exp_addr || param !== exp_param) begin
          failures++;
          $display("FAIL rand_frame[%0d]: tx=%h a=%0b p=%h required tx=%h a=%0b p=%h",
                   f, tx_q[0], address, param, resp, exp_addr, exp_param);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ack_basic();
    test_stall();
    test_nack();
    test_timeout();
    test_noise();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
